// File: rtl/axil_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axil_arb_pkg : shared FSM state encoding and AXI response codes
// Rev 1.0
// ---------------------------------------------------------------------------
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : round-robin pick of the first requester at/after the pointer
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               aclk,
  input  logic               aclk_reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] pick_vec;

  // Requests at or above the pointer win; otherwise wrap to the lowest requester.
  always_comb begin
    masked    = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      masked[i] = req[i] && (IDX_W'(i) >= ptr);
    end
    pick_vec = (|masked) ? masked : req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick_vec[i]) grant_idx = IDX_W'(i);
    end
    grant_valid = |req;
    grant       = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  always_ff @(posedge aclk) begin
    if (!aclk_reset_n) begin
      ptr <= '0;
    end else if (en && grant_valid) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axil_req_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axil_req_arbiter : shares one AXI-Lite master among NUM_REQ req/ack clients
// Rev 1.0
// ---------------------------------------------------------------------------
module axil_req_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                             aclk,
  input  logic                             aclk_reset_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_wstrb,
  output logic [NUM_REQ-1:0]               ack,
  output logic [DATA_WIDTH-1:0]            ack_rdata,
  output logic [1:0]                       ack_resp,
  output logic [ADDR_WIDTH-1:0]            m_awaddr,
  output logic [2:0]                       m_awprot,
  output logic                             m_awvalid,
  input  logic                             m_awready,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  output logic [DATA_WIDTH/8-1:0]          m_wstrb,
  output logic                             m_wvalid,
  input  logic                             m_wready,
  input  logic [1:0]                       m_bresp,
  input  logic                             m_bvalid,
  output logic                             m_bready,
  output logic [ADDR_WIDTH-1:0]            m_araddr,
  output logic [2:0]                       m_arprot,
  output logic                             m_arvalid,
  input  logic                             m_arready,
  input  logic [DATA_WIDTH-1:0]            m_rdata,
  input  logic [1:0]                       m_rresp,
  input  logic                             m_rvalid,
  output logic                             m_rready,
  output logic                             busy,
  output logic                             timeout_err
);
  import axil_arb_pkg::*;

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  state_t              state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [15:0]         wd_cnt;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic                waiting;
  logic                progress;
  logic                abort;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .aclk        (aclk),
    .aclk_reset_n(aclk_reset_n),
    .req         (req),
    .en          (state == IDLE),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // progress = the current wait state completes on this edge
  always_comb begin
    waiting  = 1'b1;
    progress = 1'b0;
    case (state)
      WR_ADDR: progress = (!m_awvalid || m_awready) && (!m_wvalid || m_wready);
      WR_RESP: progress = m_bvalid;
      RD_ADDR: progress = m_arready;
      RD_DATA: progress = m_rvalid;
      default: waiting  = 1'b0;
    endcase
    abort = waiting && !progress && (wd_cnt == 16'(TIMEOUT - 1));
  end

  always_ff @(posedge aclk) begin
    if (!aclk_reset_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      grant_q     <= '0;
      wd_cnt      <= '0;
      m_awvalid   <= 1'b0;
      m_wvalid    <= 1'b0;
      m_bready    <= 1'b0;
      m_arvalid   <= 1'b0;
      m_rready    <= 1'b0;
      ack         <= '0;
      ack_rdata   <= '0;
      ack_resp    <= RESP_OKAY;
      timeout_err <= 1'b0;
    end else begin
      if (waiting) wd_cnt <= progress ? 16'd0 : wd_cnt + 16'd1;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (arb_valid) begin
            addr_q  <= req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q <= req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
            wstrb_q <= req_wstrb[arb_idx*STRB_W +: STRB_W];
            grant_q <= arb_grant;
            if (req_we[arb_idx]) begin
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= WR_ADDR;
            end else begin
              m_arvalid <= 1'b1;
              state     <= RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
          if (progress) begin
            m_bready <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid) begin
            m_bready  <= 1'b0;
            ack       <= grant_q;
            ack_resp  <= m_bresp;
            ack_rdata <= '0;
            state     <= DONE;
          end
        end
        RD_ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_rvalid) begin
            m_rready  <= 1'b0;
            ack       <= grant_q;
            ack_resp  <= m_rresp;
            ack_rdata <= m_rdata;
            state     <= DONE;
          end
        end
        DONE: begin
          ack   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Watchdog abort overrides whatever the wait state decided above.
      if (abort) begin
        m_awvalid   <= 1'b0;
        m_wvalid    <= 1'b0;
        m_bready    <= 1'b0;
        m_arvalid   <= 1'b0;
        m_rready    <= 1'b0;
        timeout_err <= 1'b1;
        ack         <= grant_q;
        ack_resp    <= RESP_SLVERR;
        ack_rdata   <= '0;
        state       <= DONE;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (aclk_reset_n && (state != IDLE) && (state != DONE)) begin
      assert (|(req & grant_q))
        else $error("axil_req_arbiter: granted client dropped req before ack");
    end
  end

  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = wstrb_q;
  assign busy     = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axil_req_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axil_req_arbiter : directed bench with a latency-programmable AXI-Lite slave
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_axil_req_arbiter;

  localparam int NR = 2;
  localparam int AW = 11;
  localparam int DW = 32;

  logic            aclk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req, req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*DW/8-1:0] req_wstrb;
  logic [NR-1:0]   ack;
  logic [DW-1:0]   ack_rdata;
  logic [1:0]      ack_resp;
  logic [AW-1:0]   m_awaddr, m_araddr;
  logic [2:0]      m_awprot, m_arprot;
  logic            m_awvalid, m_awready, m_wvalid, m_wready;
  logic [DW-1:0]   m_wdata, m_rdata;
  logic [DW/8-1:0] m_wstrb;
  logic [1:0]      m_bresp, m_rresp;
  logic            m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic            busy, timeout_err;

  always #5 aclk = ~aclk;

  axil_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(255)) dut (
    .aclk(aclk), .aclk_reset_n(rst_n),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .ack(ack), .ack_rdata(ack_rdata), .ack_resp(ack_resp),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Slave: each ready/valid appears after a programmable number of wait cycles.
  int aw_lat, w_lat, b_lat, ar_lat, r_lat;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic aw_done, w_done, rd_pend;
  logic [DW-1:0] s_rdata;

  assign m_awready = m_awvalid && (aw_cnt >= aw_lat);
  assign m_wready  = m_wvalid && (w_cnt >= w_lat);
  assign m_bvalid  = aw_done && w_done && (b_cnt >= b_lat);
  assign m_bresp   = 2'b00;
  assign m_arready = m_arvalid && (ar_cnt >= ar_lat);
  assign m_rvalid  = rd_pend && (r_cnt >= r_lat);
  assign m_rdata   = s_rdata;
  assign m_rresp   = 2'b00;

  always @(posedge aclk) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_done <= 1'b0; w_done <= 1'b0; rd_pend <= 1'b0;
    end else begin
      aw_cnt <= (!m_awvalid || m_awready) ? 0 : aw_cnt + 1;
      w_cnt  <= (!m_wvalid || m_wready) ? 0 : w_cnt + 1;
      ar_cnt <= (!m_arvalid || m_arready) ? 0 : ar_cnt + 1;
      if (m_awvalid && m_awready) aw_done <= 1'b1;
      if (m_wvalid && m_wready)   w_done  <= 1'b1;
      if (m_bvalid && m_bready) begin
        aw_done <= 1'b0; w_done <= 1'b0; b_cnt <= 0;
      end else if (aw_done && w_done) b_cnt <= b_cnt + 1;
      if (m_arvalid && m_arready) rd_pend <= 1'b1;
      if (m_rvalid && m_rready) begin
        rd_pend <= 1'b0; r_cnt <= 0;
      end else if (rd_pend) r_cnt <= r_cnt + 1;
    end
  end

  // Bus monitor, sampled mid-cycle.
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, ar_hi = 0, ack_n = 0, bad_ack = 0;
  logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
  logic [DW-1:0] last_wdata = '0;
  logic [NR-1:0] ack_who [32];

  always @(negedge aclk) begin
    if (m_awvalid && m_awready) begin aw_hs++; last_awaddr = m_awaddr; end
    if (m_wvalid && m_wready)   begin w_hs++;  last_wdata  = m_wdata;  end
    if (m_bvalid && m_bready)   b_hs++;
    if (m_arvalid && m_arready) begin ar_hs++; last_araddr = m_araddr; end
    if (m_arvalid) ar_hi++;
    if (|ack) begin
      if ($countones(ack) != 1) bad_ack++;
      ack_who[ack_n % 32] = ack;
      ack_n++;
    end
  end

  int vecs = 0, fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic issue(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[c]             = we;
    req_addr[c*AW +: AW]  = a;
    req_wdata[c*DW +: DW] = d;
    req_wstrb[c*4 +: 4]   = 4'hF;
    req[c]                = 1'b1;
  endtask

  // lat counts cycles from the request cycle through the ack cycle inclusive.
  task automatic wait_ack(input int c, output int lat, output logic got);
    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge aclk); #1;
      lat++;
      if (ack[c]) begin got = 1'b1; break; end
    end
  endtask

  int lat, n0, hs0, hs1, hs2, hs3;
  logic got;
  logic [7:0] seq;

  initial begin
    rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0; s_rdata = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_ctrl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, busy, timeout_err}, 0);
    check("rst_ack", ack, 0);
    check("rst_rdata", ack_rdata, 0);
    check("rst_resp", ack_resp, 0);
    rst_n = 1'b1;
    @(posedge aclk); #1;

    // Single write, zero-wait slave
    hs0 = aw_hs; hs1 = w_hs; hs2 = b_hs;
    issue(0, 1'b1, 11'h010, 32'hA5A5_1234);
    wait_ack(0, lat, got);
    req[0] = 1'b0;
    check("wr_got", got, 1);
    check("wr_lat", lat, 4);
    check("wr_resp", ack_resp, 2'b00);
    check("wr_rdata", ack_rdata, 0);
    @(posedge aclk); #1;
    check("wr_ack_pulse", ack, 0);
    check("wr_idle", busy, 0);
    check("wr_beats", {8'(aw_hs - hs0), 8'(w_hs - hs1), 8'(b_hs - hs2)}, 24'h010101);
    check("wr_awaddr", last_awaddr, 11'h010);
    check("wr_wdata", last_wdata, 32'hA5A5_1234);

    // Read with 3 arready wait cycles
    ar_lat = 3; s_rdata = 32'hDEAD_BEEF;
    hs0 = ar_hi; hs1 = ar_hs;
    issue(1, 1'b0, 11'h004, 32'h0);
    wait_ack(1, lat, got);
    req[1] = 1'b0;
    check("rd_got", got, 1);
    check("rd_lat", lat, 7);
    check("rd_rdata", ack_rdata, 32'hDEAD_BEEF);
    check("rd_resp", ack_resp, 2'b00);
    check("rd_arvalid_cycles", ar_hi - hs0, 4);
    check("rd_ar_beats", ar_hs - hs1, 1);
    check("rd_araddr", last_araddr, 11'h004);
    @(posedge aclk); #1;

    // Slave never accepts the read address: watchdog abort
    ar_lat = 100000;
    hs0 = ar_hi;
    issue(0, 1'b0, 11'h020, 32'h0);
    wait_ack(0, lat, got);
    req[0] = 1'b0;
    check("to_got", got, 1);
    check("to_lat", lat, 257);
    check("to_resp", ack_resp, 2'b10);
    check("to_rdata", ack_rdata, 0);
    check("to_err", timeout_err, 1);
    check("to_arvalid_cycles", ar_hi - hs0, 255);
    @(posedge aclk); #1;
    check("to_arvalid_low", m_arvalid, 0);
    ar_lat = 0;

    // Both clients requesting continuously: strict alternation
    s_rdata = 32'h1234_5678;
    n0 = ack_n; hs0 = bad_ack;
    issue(0, 1'b1, 11'h100, 32'h1111_1111);
    issue(1, 1'b0, 11'h104, 32'h0);
    for (int k = 0; k < 200; k++) begin
      @(negedge aclk); #1;
      if (ack_n - n0 >= 8) break;
    end
    req = '0;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    check("rr_count", ack_n - n0, 8);
    check("rr_onehot", bad_ack - hs0, 0);
    for (int i = 0; i < 8; i++) seq[i] = ack_who[(n0 + i) % 32][1];
    check("rr_order", seq, 8'h55);
    check("rr_idle", busy, 0);
    check("rr_err_sticky", timeout_err, 1);

    // AW and W ready in either order
    aw_lat = 0; w_lat = 2;
    hs2 = b_hs;
    issue(0, 1'b1, 11'h030, 32'hCAFE_0001);
    @(posedge aclk); #1;
    check("ord1_both_valid", {m_awvalid, m_wvalid}, 2'b11);
    @(posedge aclk); #1;
    check("ord1_aw_first", {m_awvalid, m_wvalid}, 2'b01);
    wait_ack(0, lat, got);
    req[0] = 1'b0;
    check("ord1_got", got, 1);
    @(posedge aclk); #1;
    aw_lat = 2; w_lat = 0;
    issue(1, 1'b1, 11'h034, 32'hCAFE_0002);
    @(posedge aclk); #1;
    check("ord2_both_valid", {m_awvalid, m_wvalid}, 2'b11);
    @(posedge aclk); #1;
    check("ord2_w_first", {m_awvalid, m_wvalid}, 2'b10);
    wait_ack(1, lat, got);
    req[1] = 1'b0;
    check("ord2_got", got, 1);
    check("ord_b_beats", b_hs - hs2, 2);
    @(posedge aclk); #1;
    aw_lat = 0; w_lat = 0;

    // Reset while waiting for B
    b_lat = 100000;
    n0 = ack_n;
    issue(0, 1'b1, 11'h040, 32'h0000_0055);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    check("rst_mid_wr_resp", {busy, m_bready}, 2'b11);
    rst_n = 1'b0; req = '0;
    @(posedge aclk); #1;
    check("rst_mid_ctrl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, busy, timeout_err}, 0);
    check("rst_mid_ack", ack, 0);
    rst_n = 1'b1; b_lat = 0;
    @(negedge aclk);
    check("rst_mid_no_ack", ack_n - n0, 0);
    @(posedge aclk); #1;
    issue(1, 1'b1, 11'h044, 32'h0000_0077);
    wait_ack(1, lat, got);
    req[1] = 1'b0;
    check("post_rst_got", got, 1);
    check("post_rst_lat", lat, 4);
    check("post_rst_resp", ack_resp, 2'b00);
    check("post_rst_awaddr", last_awaddr, 11'h044);
    @(posedge aclk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
